// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS control unit: walks the shared datapath through fetch, decode,
// execute, memory and write-back states and decodes the datapath controls from the state.
module mcpu_ctrl_fsm #(
   parameter bit MEM_WAIT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OPcode,
   input  logic [5:0] Fun,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       Branch_ne,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALU_Control,
   output logic [1:0] PCSource,
   output logic [1:0] Ext_mode,
   output logic       CPU_MIO,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IF   = 4'd0,
      S_ID   = 4'd1,
      S_MA   = 4'd2,
      S_LWRD = 4'd3,
      S_LWWB = 4'd4,
      S_SWWR = 4'd5,
      S_REX  = 4'd6,
      S_RWB  = 4'd7,
      S_BR   = 4'd8,
      S_J    = 4'd9,
      S_IEX  = 4'd10,
      S_IWB  = 4'd11,
      S_JAL  = 4'd12,
      S_JR   = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SRL   = 6'b000010;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;
   localparam logic [2:0] ALU_NOR  = 3'b100;
   localparam logic [2:0] ALU_SRL  = 3'b101;

   localparam logic [1:0] EXT_SIGN = 2'b00;
   localparam logic [1:0] EXT_ZERO = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   state_e     state_q, state_d;
   logic       mem_done;
   logic [2:0] r_alu;
   logic [2:0] i_alu;
   logic [1:0] i_ext;
   logic       is_itype;
   logic       unused_zero;

   // The branch decision is taken in the datapath; zero is only carried for the top level.
   assign unused_zero = zero;
   assign mem_done    = MEM_WAIT ? MIO_ready : 1'b1;
   assign state       = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      r_alu = ALU_ADD;
      case (Fun)
         FN_ADD:  r_alu = ALU_ADD;
         FN_SUB:  r_alu = ALU_SUB;
         FN_AND:  r_alu = ALU_AND;
         FN_OR:   r_alu = ALU_OR;
         FN_SLT:  r_alu = ALU_SLT;
         FN_NOR:  r_alu = ALU_NOR;
         FN_SRL:  r_alu = ALU_SRL;
         default: r_alu = ALU_ADD;
      endcase
   end

   // lui goes through the OR path; rs is $0 by encoding so the result is imm<<16.
   always_comb begin
      i_alu    = ALU_ADD;
      i_ext    = EXT_SIGN;
      is_itype = 1'b1;
      case (OPcode)
         OP_ADDI: begin i_alu = ALU_ADD; i_ext = EXT_SIGN; end
         OP_ANDI: begin i_alu = ALU_AND; i_ext = EXT_ZERO; end
         OP_ORI:  begin i_alu = ALU_OR;  i_ext = EXT_ZERO; end
         OP_SLTI: begin i_alu = ALU_SLT; i_ext = EXT_SIGN; end
         OP_LUI:  begin i_alu = ALU_OR;  i_ext = EXT_LUI;  end
         default: is_itype = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:   if (mem_done) state_d = S_ID;
         S_ID: begin
            case (OPcode)
               OP_RTYPE:      state_d = (Fun == FN_JR) ? S_JR : S_REX;
               OP_LW, OP_SW:  state_d = S_MA;
               OP_BEQ, OP_BNE: state_d = S_BR;
               OP_J:          state_d = S_J;
               OP_JAL:        state_d = S_JAL;
               default:       state_d = is_itype ? S_IEX : S_IF;
            endcase
         end
         S_MA:   state_d = (OPcode == OP_LW) ? S_LWRD : S_SWWR;
         S_LWRD: if (mem_done) state_d = S_LWWB;
         S_SWWR: if (mem_done) state_d = S_IF;
         S_REX:  state_d = S_RWB;
         S_IEX:  state_d = S_IWB;
         S_LWWB, S_RWB, S_BR, S_J, S_IWB, S_JAL, S_JR: state_d = S_IF;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      Branch_ne   = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALU_Control = ALU_ADD;
      PCSource    = 2'b00;
      Ext_mode    = EXT_SIGN;
      CPU_MIO     = 1'b0;
      case (state_q)
         S_IF: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_done;
            PCWrite = mem_done;
            CPU_MIO = 1'b1;
         end
         S_ID:   ALUSrcB = 2'b11;
         S_MA: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_LWRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            CPU_MIO = 1'b1;
         end
         S_LWWB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
         end
         S_SWWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            CPU_MIO  = 1'b1;
         end
         S_REX: begin
            ALUSrcA     = 1'b1;
            ALU_Control = r_alu;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
         end
         S_BR: begin
            ALUSrcA     = 1'b1;
            ALU_Control = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            Branch_ne   = OPcode[0];
         end
         S_J: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         S_JAL: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
         end
         S_IEX: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b10;
            ALU_Control = i_alu;
            Ext_mode    = i_ext;
         end
         // ALU/extender stay as in I_EX so ALUOut is stable through write-back.
         S_IWB: begin
            RegWrite    = 1'b1;
            ALU_Control = i_alu;
            Ext_mode    = i_ext;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: an instruction-level model expands each instruction into its
// expected per-cycle control bundle; a compare process checks the DUT every cycle.
module tb_mcpu_ctrl_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcwc, bne, iord, mrd, mwr, irw, rw;
      logic [1:0] rdst, m2r;
      logic       asa;
      logic [1:0] asb;
      logic [2:0] alu;
      logic [1:0] pcs, ext;
      logic       mio;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset, zero, MIO_ready;
   logic [5:0] OPcode, Fun;
   logic       PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite, RegWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, Ext_mode;
   logic       ALUSrcA, CPU_MIO;
   logic [2:0] ALU_Control;
   logic [3:0] state;

   logic [26:0] exp_q[$];
   ctl_t        obs_q[$];
   ctl_t        obs;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [5:0]  cur_op, cur_fun;

   mcpu_ctrl_fsm #(.MEM_WAIT(1'b1)) dut (
      .clk(clk), .reset(reset), .OPcode(OPcode), .Fun(Fun), .zero(zero),
      .MIO_ready(MIO_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .Branch_ne(Branch_ne), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control),
      .PCSource(PCSource), .Ext_mode(Ext_mode), .CPU_MIO(CPU_MIO), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite,
                 RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALU_Control, PCSource,
                 Ext_mode, CPU_MIO};

   function automatic ctl_t base(input logic [3:0] st);
      ctl_t e;
      e     = '0;
      e.st  = st;
      e.alu = 3'b010;
      return e;
   endfunction

   function automatic ctl_t gated(input ctl_t e);
      ctl_t g;
      g = e;
      g.pcw = 1'b0; g.pcwc = 1'b0; g.mrd = 1'b0; g.mwr = 1'b0; g.irw = 1'b0; g.rw = 1'b0;
      return g;
   endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] fn);
      if (fn == 6'h22) return 3'b110;
      if (fn == 6'h24) return 3'b000;
      if (fn == 6'h25) return 3'b001;
      if (fn == 6'h2A) return 3'b111;
      if (fn == 6'h27) return 3'b100;
      if (fn == 6'h02) return 3'b101;
      return 3'b010;
   endfunction

   // {valid, alu, ext} for the immediate-format opcodes
   function automatic logic [5:0] i_info(input logic [5:0] op);
      if (op == 6'h08) return {1'b1, 3'b010, 2'b00};
      if (op == 6'h0C) return {1'b1, 3'b000, 2'b01};
      if (op == 6'h0D) return {1'b1, 3'b001, 2'b01};
      if (op == 6'h0A) return {1'b1, 3'b111, 2'b00};
      if (op == 6'h0F) return {1'b1, 3'b001, 2'b10};
      return 6'b0;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [63:0] trace();
      logic [63:0] t;
      t = '0;
      foreach (obs_q[i]) t = {t[59:0], obs_q[i].st};
      return t;
   endfunction

   task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic rdy, input logic rst, input bit chk, input ctl_t e);
      @(posedge clk);
      #1;
      OPcode    = cur_op;
      Fun       = cur_fun;
      MIO_ready = rdy;
      reset     = rst;
      zero      = rnd();
      if (chk) exp_q.push_back(e);
   endtask

   task automatic fetch(input int if_wait);
      ctl_t e;
      e = base(4'd0); e.mrd = 1'b1; e.asb = 2'b01; e.mio = 1'b1;
      for (int i = 0; i < if_wait; i++) cyc(1'b0, 1'b0, 1'b1, e);
      e.irw = 1'b1; e.pcw = 1'b1;
      cyc(1'b1, 1'b0, 1'b1, e);
      e = base(4'd1); e.asb = 2'b11;
      cyc(rnd(), 1'b0, 1'b1, e);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int if_wait, input int mem_wait);
      ctl_t       e;
      logic [5:0] ii;
      obs_q.delete();
      cur_op  = op;
      cur_fun = fn;
      ii      = i_info(op);
      fetch(if_wait);
      if (op == 6'h00 && fn == 6'h08) begin
         e = base(4'd13); e.pcw = 1'b1; e.pcs = 2'b11; cyc(rnd(), 1'b0, 1'b1, e);
      end else if (op == 6'h00) begin
         e = base(4'd6); e.asa = 1'b1; e.alu = r_alu(fn); cyc(rnd(), 1'b0, 1'b1, e);
         e = base(4'd7); e.rw = 1'b1; e.rdst = 2'b01; cyc(rnd(), 1'b0, 1'b1, e);
      end else if (op == 6'h23 || op == 6'h2B) begin
         e = base(4'd2); e.asa = 1'b1; e.asb = 2'b10; cyc(rnd(), 1'b0, 1'b1, e);
         if (op == 6'h23) begin
            e = base(4'd3); e.mrd = 1'b1; e.iord = 1'b1; e.mio = 1'b1;
         end else begin
            e = base(4'd5); e.mwr = 1'b1; e.iord = 1'b1; e.mio = 1'b1;
         end
         for (int i = 0; i < mem_wait; i++) cyc(1'b0, 1'b0, 1'b1, e);
         cyc(1'b1, 1'b0, 1'b1, e);
         if (op == 6'h23) begin
            e = base(4'd4); e.rw = 1'b1; e.m2r = 2'b01; cyc(rnd(), 1'b0, 1'b1, e);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         e = base(4'd8); e.asa = 1'b1; e.alu = 3'b110; e.pcwc = 1'b1; e.pcs = 2'b01;
         e.bne = op[0];
         cyc(rnd(), 1'b0, 1'b1, e);
      end else if (op == 6'h02) begin
         e = base(4'd9); e.pcw = 1'b1; e.pcs = 2'b10; cyc(rnd(), 1'b0, 1'b1, e);
      end else if (op == 6'h03) begin
         e = base(4'd12); e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.rdst = 2'b10;
         e.m2r = 2'b10;
         cyc(rnd(), 1'b0, 1'b1, e);
      end else if (ii[5]) begin
         e = base(4'd10); e.asa = 1'b1; e.asb = 2'b10; e.alu = ii[4:2]; e.ext = ii[1:0];
         cyc(rnd(), 1'b0, 1'b1, e);
         e = base(4'd11); e.rw = 1'b1; e.alu = ii[4:2]; e.ext = ii[1:0];
         cyc(rnd(), 1'b0, 1'b1, e);
      end
      @(negedge clk);
      #1;
   endtask

   initial begin
      ctl_t e;
      reset = 1'b1; zero = 1'b0; MIO_ready = 1'b0; OPcode = '0; Fun = '0;
      cur_op = '0; cur_fun = '0;
      fork
         begin : compare
            forever begin
               ctl_t x;
               @(negedge clk);
               if (exp_q.size() > 0) begin
                  x = exp_q.pop_front();
                  n_checks++;
                  obs_q.push_back(obs);
                  if (obs !== x) begin
                     n_fail++;
                     $display("FAIL cycle_ctl st=%0d: got %h expected %h", x.st, obs, x);
                  end
               end
            end
         end
      join_none

      // power-on reset, second cycle checked with strobes held low
      obs_q.delete();
      cyc(1'b0, 1'b1, 1'b0, base(4'd0));
      e = base(4'd0); e.mrd = 1'b1; e.asb = 2'b01; e.mio = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, gated(e));
      @(negedge clk); #1;
      lit("reset_state", 64'(obs_q[0].st), 64'h0);
      lit("reset_memread", 64'(obs_q[0].mrd), 64'h0);

      run_instr(6'h00, 6'h20, 0, 0);
      lit("add_states", trace(), 64'h0167);
      lit("add_rwb", 64'({obs_q[3].rw, obs_q[3].rdst, obs_q[3].alu}), 64'b1_01_010);

      run_instr(6'h23, 6'h00, 0, 3);
      lit("lw_states", trace(), 64'h01233334);
      lit("lw_rd_strobes", 64'({obs_q[3].mrd, obs_q[3].iord}), 64'b11);

      run_instr(6'h04, 6'h00, 0, 0);
      lit("beq_br", 64'({obs_q[2].pcwc, obs_q[2].pcs, obs_q[2].bne}), 64'b1_01_0);
      run_instr(6'h05, 6'h00, 0, 0);
      lit("bne_br", 64'({obs_q[2].pcwc, obs_q[2].pcs, obs_q[2].bne}), 64'b1_01_1);

      run_instr(6'h0D, 6'h00, 0, 0);
      lit("ori_iex", 64'({obs_q[2].ext, obs_q[2].alu}), 64'b01_001);
      run_instr(6'h0F, 6'h00, 0, 0);
      lit("lui_ext", 64'(obs_q[2].ext), 64'b10);
      run_instr(6'h08, 6'h00, 0, 0);
      lit("addi_ext", 64'(obs_q[3].ext), 64'b00);

      run_instr(6'h03, 6'h00, 0, 0);
      lit("jal_states", trace(), 64'h01C);
      lit("jal_ctl", 64'({obs_q[2].pcw, obs_q[2].pcs, obs_q[2].rdst, obs_q[2].m2r}),
          64'b1_10_10_10);

      run_instr(6'h3F, 6'h00, 0, 0);
      lit("badop_len", 64'(obs_q.size()), 64'd2);

      run_instr(6'h00, 6'h22, 2, 0);
      lit("ifwait_states", trace(), 64'h000167);
      run_instr(6'h00, 6'h24, 0, 0);
      run_instr(6'h00, 6'h25, 0, 0);
      run_instr(6'h00, 6'h2A, 0, 0);
      run_instr(6'h00, 6'h27, 0, 0);
      run_instr(6'h00, 6'h02, 1, 0);
      run_instr(6'h00, 6'h3F, 0, 0);
      run_instr(6'h00, 6'h08, 0, 0);
      lit("jr_states", trace(), 64'h01D);
      run_instr(6'h02, 6'h00, 0, 0);
      run_instr(6'h0C, 6'h00, 0, 0);
      run_instr(6'h0A, 6'h00, 0, 0);
      run_instr(6'h2B, 6'h00, 1, 2);
      run_instr(6'h01, 6'h00, 0, 0);
      run_instr(6'h23, 6'h00, 1, 0);

      // reset while a store is held waiting for memory
      obs_q.delete();
      cur_op = 6'h2B; cur_fun = 6'h00;
      fetch(0);
      e = base(4'd2); e.asa = 1'b1; e.asb = 2'b10; cyc(rnd(), 1'b0, 1'b1, e);
      e = base(4'd5); e.mwr = 1'b1; e.iord = 1'b1; e.mio = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, e);
      cyc(1'b1, 1'b1, 1'b1, gated(e));
      e = base(4'd0); e.mrd = 1'b1; e.asb = 2'b01; e.mio = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, gated(e));
      @(negedge clk); #1;
      lit("swrst_states", trace(), 64'h012550);
      lit("swrst_hold_mwr", 64'(obs_q[3].mwr), 64'h1);
      lit("swrst_mwr", 64'({obs_q[4].mwr, obs_q[5].mwr, obs_q[5].pcw}), 64'h0);

      run_instr(6'h00, 6'h20, 0, 0);
      lit("after_rst_states", trace(), 64'h0167);

      repeat (2) @(posedge clk);
      lit("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
